riscv_v_wb_pipe: RTL and testbench

// - Vector MEM->WB result pipeline, downstream of the vector execute stage.
// - Captures execute results (byte-enables, rd, data) and holds them for one MEM stage, then one WB stage.
// - Commits to the vector RF write port through a valid/ready handshake.
// - Drives the MEM/WB bypass signals (rf_wr_en/addr/data _mem/_wb) consumed by the execute-stage bypass unit.

---
 rtl/riscv_v_pkg.sv | 20 ++
 rtl/riscv_v_pipe_stage.sv | 46 ++++
 rtl/riscv_v_wb_pipe.sv | 97 +++++++++
 tb/tb_riscv_v_wb_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit types: register data, byte enables, destination index,
// and the payload carried through the MEM/WB result stages.
package riscv_v_pkg;

  localparam int VLEN     = 128;
  localparam int VRF_EN_W = VLEN / 8;
  localparam int RD_W     = 5;

  typedef logic [VLEN-1:0]     riscv_v_data_t;
  typedef logic [VRF_EN_W-1:0] riscv_v_rf_wr_en_t;
  typedef logic [RD_W-1:0]     riscv_instr_rd_t;

  typedef struct packed {
    logic               valid;
    riscv_v_rf_wr_en_t  en;
    riscv_instr_rd_t    addr;
    riscv_v_data_t      data;
  } riscv_v_wb_stage_t;

endpackage

// File: rtl/riscv_v_pipe_stage.sv
// One valid/ready register slice holding a vector write-back payload.
// The payload is only reloaded on acceptance, so it holds after the entry leaves.
module riscv_v_pipe_stage
  import riscv_v_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  riscv_v_wb_stage_t in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output riscv_v_wb_stage_t out_data,
  input  logic              kill
);

  riscv_v_wb_stage_t stage_q;
  riscv_v_wb_stage_t stage_d;

  assign in_ready  = ~stage_q.valid | out_ready;
  assign out_valid = stage_q.valid;
  assign out_data  = stage_q;

  // Kill drops only the occupancy; the payload keeps its last captured value.
  always_comb begin
    stage_d = stage_q;
    if (in_valid && in_ready) begin
      stage_d       = in_data;
      stage_d.valid = 1'b1;
    end else if (out_ready) begin
      stage_d.valid = 1'b0;
    end
    if (kill) begin
      stage_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/riscv_v_wb_pipe.sv
// Vector MEM->WB result pipeline: two register slices feeding the vector RF
// write port, plus the MEM/WB bypass outputs and a committed-write counter.
module riscv_v_wb_pipe
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int EN_W   = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  output logic              exe_ready,
  input  logic [EN_W-1:0]   exe_wr_en,
  input  logic [ADDR_W-1:0] exe_wr_addr,
  input  logic [DATA_W-1:0] exe_wr_data,
  input  logic              flush,
  output logic [EN_W-1:0]   rf_wr_en_mem,
  output logic [ADDR_W-1:0] rf_wr_addr_mem,
  output logic [DATA_W-1:0] rf_wr_data_mem,
  output logic [EN_W-1:0]   rf_wr_en_wb,
  output logic [ADDR_W-1:0] rf_wr_addr_wb,
  output logic [DATA_W-1:0] rf_wr_data_wb,
  output logic              rf_wr_valid,
  input  logic              rf_wr_ready,
  output logic [CNT_W-1:0]  wb_count
);

  riscv_v_wb_stage_t exe_in;
  riscv_v_wb_stage_t mem_out;
  riscv_v_wb_stage_t wb_out;
  logic              mem_valid;
  logic              wb_valid;
  logic              wb_in_ready;
  logic              capture;
  logic              wb_fire;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  always_comb begin
    exe_in       = '0;
    exe_in.valid = 1'b1;
    exe_in.en    = exe_wr_en;
    exe_in.addr  = exe_wr_addr;
    exe_in.data  = exe_wr_data;
  end

  // All-zero enables complete the handshake without occupying a stage.
  assign capture = exe_valid & exe_ready & (|exe_wr_en) & ~flush;
  assign wb_fire = wb_valid & rf_wr_ready;

  riscv_v_pipe_stage u_mem (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (capture),
    .in_ready  (exe_ready),
    .in_data   (exe_in),
    .out_valid (mem_valid),
    .out_ready (wb_in_ready),
    .out_data  (mem_out),
    .kill      (flush)
  );

  // WB is never killed: anything that reached it is already ordered for commit.
  riscv_v_pipe_stage u_wb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mem_valid),
    .in_ready  (wb_in_ready),
    .in_data   (mem_out),
    .out_valid (wb_valid),
    .out_ready (rf_wr_ready),
    .out_data  (wb_out),
    .kill      (1'b0)
  );

  assign rf_wr_en_mem   = mem_valid ? mem_out.en : '0;
  assign rf_wr_addr_mem = mem_out.addr;
  assign rf_wr_data_mem = mem_out.data;
  assign rf_wr_en_wb    = wb_out.valid ? wb_out.en : '0;
  assign rf_wr_addr_wb  = wb_out.addr;
  assign rf_wr_data_wb  = wb_out.data;
  assign rf_wr_valid    = wb_valid;

  assign cnt_d    = wb_fire ? cnt_q + 1'b1 : cnt_q;
  assign wb_count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_v_wb_pipe.sv
// Bench for riscv_v_wb_pipe: directed vector table, async reset, counter wrap
// and random traffic, all compared against an entry-queue reference model.
module tb_riscv_v_wb_pipe;

  typedef struct {
    logic         v;
    logic [15:0]  en;
    logic [4:0]   a;
    logic [127:0] d;
    logic         fl;
    logic         rdy;
    logic         xRdy;
    logic         xWbV;
    logic [15:0]  xWbEn;
    logic [4:0]   xWbA;
    logic [15:0]  xMemEn;
    logic [4:0]   xMemA;
    logic [15:0]  xCnt;
  } vec_t;

  typedef struct {
    logic [15:0]  en;
    logic [4:0]   a;
    logic [127:0] d;
  } ent_t;

  logic         clk;
  logic         rst;
  logic         exeValid;
  logic [15:0]  exeWrEn;
  logic [4:0]   exeWrAddr;
  logic [127:0] exeWrData;
  logic         flush;
  logic         rfWrReady;

  logic         exeReady,  exeReady4;
  logic [15:0]  memEn,     memEn4;
  logic [4:0]   memAddr,   memAddr4;
  logic [127:0] memData,   memData4;
  logic [15:0]  wbEn,      wbEn4;
  logic [4:0]   wbAddr,    wbAddr4;
  logic [127:0] wbData,    wbData4;
  logic         rfWrValid, rfWrValid4;
  logic [15:0]  wbCount;
  logic [3:0]   wbCount4;

  int   checks;
  int   errors;
  ent_t pipeQ[$];
  bit   headInWb;
  ent_t memLast;
  ent_t wbLast;
  int   modelCnt;
  int   commitLog[$];
  vec_t tbl[$];

  riscv_v_wb_pipe dut (
    .clk(clk), .rst(rst), .exe_valid(exeValid), .exe_ready(exeReady),
    .exe_wr_en(exeWrEn), .exe_wr_addr(exeWrAddr), .exe_wr_data(exeWrData),
    .flush(flush), .rf_wr_en_mem(memEn), .rf_wr_addr_mem(memAddr),
    .rf_wr_data_mem(memData), .rf_wr_en_wb(wbEn), .rf_wr_addr_wb(wbAddr),
    .rf_wr_data_wb(wbData), .rf_wr_valid(rfWrValid), .rf_wr_ready(rfWrReady),
    .wb_count(wbCount)
  );

  riscv_v_wb_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .exe_valid(exeValid), .exe_ready(exeReady4),
    .exe_wr_en(exeWrEn), .exe_wr_addr(exeWrAddr), .exe_wr_data(exeWrData),
    .flush(flush), .rf_wr_en_mem(memEn4), .rf_wr_addr_mem(memAddr4),
    .rf_wr_data_mem(memData4), .rf_wr_en_wb(wbEn4), .rf_wr_addr_wb(wbAddr4),
    .rf_wr_data_wb(wbData4), .rf_wr_valid(rfWrValid4), .rf_wr_ready(rfWrReady),
    .wb_count(wbCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [15:0] en, logic [4:0] a, logic [127:0] d,
                              logic fl, logic rdy, logic xRdy, logic xWbV,
                              logic [15:0] xWbEn, logic [4:0] xWbA, logic [15:0] xMemEn,
                              logic [4:0] xMemA, logic [15:0] xCnt);
    vec_t r;
    r.v = v; r.en = en; r.a = a; r.d = d; r.fl = fl; r.rdy = rdy;
    r.xRdy = xRdy; r.xWbV = xWbV; r.xWbEn = xWbEn; r.xWbA = xWbA;
    r.xMemEn = xMemEn; r.xMemA = xMemA; r.xCnt = xCnt;
    return r;
  endfunction

  function automatic vec_t stim(logic v, logic [15:0] en, logic [4:0] a, logic [127:0] d,
                                logic fl, logic rdy);
    return mk(v, en, a, d, fl, rdy, 1'b0, 1'b0, 16'h0, 5'h0, 16'h0, 5'h0, 16'h0);
  endfunction

  task automatic modelReset();
    pipeQ.delete();
    headInWb = 1'b0;
    memLast  = '{en: 16'h0, a: 5'h0, d: 128'h0};
    wbLast   = '{en: 16'h0, a: 5'h0, d: 128'h0};
    modelCnt = 0;
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input vec_t s);
    exeValid  = s.v;
    exeWrEn   = s.en;
    exeWrAddr = s.a;
    exeWrData = s.d;
    flush     = s.fl;
    rfWrReady = s.rdy;
    #1;
  endtask

  // Compare both DUT instances against the queue model, then advance the model
  // across the coming rising edge.
  task automatic checkModel(input vec_t s);
    bit   wbV, memV, expRdy, fire, adv, cap;
    logic [15:0] cnt;
    wbV    = (pipeQ.size() > 0) && headInWb;
    memV   = pipeQ.size() > (headInWb ? 1 : 0);
    expRdy = !memV || !wbV || s.rdy;
    cnt    = 16'(modelCnt);
    chk("exe_ready",   128'(exeReady),   128'(expRdy));
    chk("rf_wr_valid", 128'(rfWrValid),  128'(wbV));
    chk("en_wb",       128'(wbEn),       128'(wbV ? wbLast.en : 16'h0));
    chk("addr_wb",     128'(wbAddr),     128'(wbLast.a));
    chk("data_wb",     wbData,           wbLast.d);
    chk("en_mem",      128'(memEn),      128'(memV ? memLast.en : 16'h0));
    chk("addr_mem",    128'(memAddr),    128'(memLast.a));
    chk("data_mem",    memData,          memLast.d);
    chk("wb_count",    128'(wbCount),    128'(cnt));
    chk("aux_exe_ready", 128'(exeReady4), 128'(expRdy));
    chk("aux_valid",   128'(rfWrValid4), 128'(wbV));
    chk("aux_en_wb",   128'(wbEn4),      128'(wbV ? wbLast.en : 16'h0));
    chk("aux_addr_wb", 128'(wbAddr4),    128'(wbLast.a));
    chk("aux_data_wb", wbData4,          wbLast.d);
    chk("aux_en_mem",  128'(memEn4),     128'(memV ? memLast.en : 16'h0));
    chk("aux_addr_mem", 128'(memAddr4),  128'(memLast.a));
    chk("aux_data_mem", memData4,        memLast.d);
    chk("aux_wb_count", 128'(wbCount4),  128'(cnt[3:0]));
    if (rfWrValid && rfWrReady) commitLog.push_back(int'(wbAddr));
    fire = wbV && s.rdy;
    adv  = memV && (!wbV || fire);
    cap  = s.v && expRdy && (s.en != 16'h0) && !s.fl;
    if (fire) begin
      void'(pipeQ.pop_front());
      headInWb = 1'b0;
      modelCnt++;
    end
    if (adv) begin
      headInWb = 1'b1;
      wbLast   = pipeQ[0];
    end
    if (s.fl && memV && !adv) void'(pipeQ.pop_back());
    if (cap) begin
      memLast = '{en: s.en, a: s.a, d: s.d};
      pipeQ.push_back(memLast);
    end
  endtask

  task automatic checkOutput(input vec_t s, input int row);
    chk($sformatf("row%0d_exe_ready", row), 128'(exeReady),  128'(s.xRdy));
    chk($sformatf("row%0d_valid", row),     128'(rfWrValid), 128'(s.xWbV));
    chk($sformatf("row%0d_en_wb", row),     128'(wbEn),      128'(s.xWbEn));
    chk($sformatf("row%0d_addr_wb", row),   128'(wbAddr),    128'(s.xWbA));
    chk($sformatf("row%0d_en_mem", row),    128'(memEn),     128'(s.xMemEn));
    chk($sformatf("row%0d_addr_mem", row),  128'(memAddr),   128'(s.xMemA));
    chk($sformatf("row%0d_wb_count", row),  128'(wbCount),   128'(s.xCnt));
  endtask

  task automatic runCycle(input vec_t s);
    applyStimulus(s);
    checkModel(s);
    @(negedge clk);
  endtask

  initial begin
    int   found6;
    int   found78;
    vec_t r;
    logic [15:0] en;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    exeValid = 1'b0; exeWrEn = '0; exeWrAddr = '0; exeWrData = '0;
    flush = 1'b0; rfWrReady = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    chk("rst_exe_ready", 128'(exeReady),  128'(1));
    chk("rst_valid",     128'(rfWrValid), 128'(0));
    chk("rst_en_wb",     128'(wbEn),      128'(0));
    chk("rst_en_mem",    128'(memEn),     128'(0));
    chk("rst_count",     128'(wbCount),   128'(0));
    rst = 1'b0;

    // Stream of four, then backpressure, flush, partial and zero enables.
    tbl.push_back(mk(1, 16'hFFFF, 1, 128'h11, 0, 1,  1, 0, 16'h0000, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 16'hFFFF, 2, 128'h22, 0, 1,  1, 0, 16'h0000, 0, 16'hFFFF, 1, 0));
    tbl.push_back(mk(1, 16'hFFFF, 3, 128'h33, 0, 1,  1, 1, 16'hFFFF, 1, 16'hFFFF, 2, 0));
    tbl.push_back(mk(1, 16'hFFFF, 4, 128'h44, 0, 1,  1, 1, 16'hFFFF, 2, 16'hFFFF, 3, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 1, 16'hFFFF, 3, 16'hFFFF, 4, 2));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 1, 16'hFFFF, 4, 16'h0000, 4, 3));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 0, 16'h0000, 4, 16'h0000, 4, 4));
    tbl.push_back(mk(1, 16'hFFFF, 11, 128'hB0, 0, 1, 1, 0, 16'h0000, 4, 16'h0000, 4, 4));
    tbl.push_back(mk(1, 16'hFFFF, 12, 128'hC0, 0, 0, 1, 0, 16'h0000, 4, 16'hFFFF, 11, 4));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 16'hFFFF, 13, 128'hD0, 0, 0, 0, 1, 16'hFFFF, 11, 16'hFFFF, 12, 4));
    tbl.push_back(mk(1, 16'hFFFF, 13, 128'hD0, 0, 1, 1, 1, 16'hFFFF, 11, 16'hFFFF, 12, 4));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 1, 16'hFFFF, 12, 16'hFFFF, 13, 5));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 1, 16'hFFFF, 13, 16'h0000, 13, 6));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 0, 16'h0000, 13, 16'h0000, 13, 7));
    tbl.push_back(mk(1, 16'hFFFF, 6, 128'h60, 0, 0,  1, 0, 16'h0000, 13, 16'h0000, 13, 7));
    tbl.push_back(mk(1, 16'hFFFF, 7, 128'h70, 0, 0,  1, 0, 16'h0000, 13, 16'hFFFF, 6, 7));
    tbl.push_back(mk(1, 16'hFFFF, 8, 128'h80, 1, 0,  0, 1, 16'hFFFF, 6, 16'hFFFF, 7, 7));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 1, 16'hFFFF, 6, 16'h0000, 7, 7));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 0, 16'h0000, 6, 16'h0000, 7, 8));
    tbl.push_back(mk(1, 16'h00F0, 9, 128'h90, 0, 1,  1, 0, 16'h0000, 6, 16'h0000, 7, 8));
    tbl.push_back(mk(1, 16'h0000, 10, 128'hA0, 0, 1, 1, 0, 16'h0000, 6, 16'h00F0, 9, 8));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 1, 16'h00F0, 9, 16'h0000, 9, 8));
    tbl.push_back(mk(0, 16'h0000, 0, 128'h0,  0, 1,  1, 0, 16'h0000, 9, 16'h0000, 9, 9));

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 17) commitLog.delete();
      applyStimulus(tbl[i]);
      checkModel(tbl[i]);
      checkOutput(tbl[i], i);
      @(negedge clk);
    end
    found6 = 0;
    found78 = 0;
    foreach (commitLog[k]) begin
      if (commitLog[k] == 6) found6++;
      if (commitLog[k] == 7 || commitLog[k] == 8) found78++;
    end
    chk("flush_vd6_commits", 128'(found6), 128'(1));
    chk("flush_vd7_vd8_dropped", 128'(found78), 128'(0));

    // Fill both stages under stall, then reset between clock edges.
    runCycle(stim(1, 16'hFFFF, 20, 128'h200, 0, 0));
    runCycle(stim(1, 16'hFFFF, 21, 128'h210, 0, 0));
    applyStimulus(stim(1, 16'hFFFF, 22, 128'h220, 0, 0));
    chk("pre_rst_full", 128'(exeReady), 128'(0));
    #1 rst = 1'b1;
    #1;
    chk("arst_valid",    128'(rfWrValid), 128'(0));
    chk("arst_en_wb",    128'(wbEn),      128'(0));
    chk("arst_addr_wb",  128'(wbAddr),    128'(0));
    chk("arst_data_wb",  wbData,          128'(0));
    chk("arst_en_mem",   128'(memEn),     128'(0));
    chk("arst_addr_mem", 128'(memAddr),   128'(0));
    chk("arst_data_mem", memData,         128'(0));
    chk("arst_count",    128'(wbCount),   128'(0));
    chk("arst_count4",   128'(wbCount4),  128'(0));
    @(negedge clk);
    rst = 1'b0;
    exeValid = 1'b0;
    modelReset();
    #1;
    chk("post_rst_exe_ready", 128'(exeReady), 128'(1));
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      runCycle(stim(1, 16'hFFFF, 5'(i), {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1));
    repeat (3) runCycle(stim(0, 16'h0, 0, 128'h0, 0, 1));
    chk("wrap_count4", 128'(wbCount4), 128'(1));
    chk("wrap_count16", 128'(wbCount), 128'(17));

    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 7))
        0:       en = 16'h0000;
        1:       en = 16'($urandom());
        default: en = 16'hFFFF;
      endcase
      r = stim($urandom_range(0, 3) != 0, en, 5'($urandom()),
               {$urandom(), $urandom(), $urandom(), $urandom()},
               $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
      runCycle(r);
    end
    repeat (4) runCycle(stim(0, 16'h0, 0, 128'h0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
